// File: rtl/timer_pkg.sv
// Shared types and digit-clamping helpers for the egg timer controller.
package timer_pkg;

   typedef enum logic [2:0] {
      StSetSec,
      StSetMin,
      StReady,
      StRun,
      StAlarm
   } state_e;

   typedef logic [3:0] bcd_t;

   localparam bcd_t SEC_TENS_MAX = 4'd5;
   localparam bcd_t DIGIT_MAX    = 4'd9;

   function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t lim);
      return (d > lim) ? lim : d;
   endfunction

   function automatic logic [7:0] clamp_sec(input logic [7:0] v);
      return {clamp_digit(v[7:4], SEC_TENS_MAX), clamp_digit(v[3:0], DIGIT_MAX)};
   endfunction

   // Digits are clamped first, then the whole minute value is limited to max_min.
   function automatic logic [7:0] clamp_min(input logic [7:0] v, input int unsigned max_min);
      bcd_t tens;
      bcd_t ones;
      tens = clamp_digit(v[7:4], DIGIT_MAX);
      ones = clamp_digit(v[3:0], DIGIT_MAX);
      if (32'(tens) * 10 + 32'(ones) > max_min) begin
         tens = bcd_t'(max_min / 10);
         ones = bcd_t'(max_min % 10);
      end
      return {tens, ones};
   endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// Four-digit MM:SS BCD register with parallel load and borrow-chained decrement.
module bcd_mmss_down
   import timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic [15:0] load_val_i,
   input  logic        dec_i,
   output logic [15:0] digits_o,
   output logic        zero_o
);

   bcd_t min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
   bcd_t min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;

   always_comb begin
      min_tens_d = min_tens_q;
      min_ones_d = min_ones_q;
      sec_tens_d = sec_tens_q;
      sec_ones_d = sec_ones_q;
      if (load_i) begin
         {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} = load_val_i;
      end else if (dec_i) begin
         if (sec_ones_q != 4'd0) begin
            sec_ones_d = sec_ones_q - 4'd1;
         end else begin
            sec_ones_d = DIGIT_MAX;
            if (sec_tens_q != 4'd0) begin
               sec_tens_d = sec_tens_q - 4'd1;
            end else begin
               // :00 wraps to :59 and borrows a minute; never decremented from 00:00
               sec_tens_d = SEC_TENS_MAX;
               if (min_ones_q != 4'd0) begin
                  min_ones_d = min_ones_q - 4'd1;
               end else begin
                  min_ones_d = DIGIT_MAX;
                  min_tens_d = min_tens_q - 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         min_tens_q <= '0;
         min_ones_q <= '0;
         sec_tens_q <= '0;
         sec_ones_q <= '0;
      end else begin
         min_tens_q <= min_tens_d;
         min_ones_q <= min_ones_d;
         sec_tens_q <= sec_tens_d;
         sec_ones_q <= sec_ones_d;
      end
   end

   assign digits_o = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
   assign zero_o   = (digits_o == 16'h0000);

endmodule

// File: rtl/egg_timer_ctrl.sv
// Countdown egg timer: set/run/alarm FSM, 1 Hz prescaler and alarm LED flasher
// around an MM:SS BCD down-counter.
module egg_timer_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned FLASH_DIV = 12_500_000,
   parameter int unsigned LED_W     = 10,
   parameter int unsigned MAX_MIN   = 99
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             startStop,
   input  logic [7:0]       sw,
   output logic [3:0]       minTens,
   output logic [3:0]       minOnes,
   output logic [3:0]       secTens,
   output logic [3:0]       secOnes,
   output logic [LED_W-1:0] leds,
   output logic             running,
   output logic             done
);

   localparam int unsigned TickW  = $clog2(TICK_DIV);
   localparam int unsigned FlashW = $clog2(FLASH_DIV);

   state_e            state_q;
   logic [TickW-1:0]  presc_q;
   logic [FlashW-1:0] flash_q;
   logic [7:0]        preset_sec_q;
   logic [7:0]        preset_min_q;

   logic [7:0]  sec_clamped;
   logic [7:0]  min_clamped;
   logic        tick;
   logic        last_sec;
   logic        cnt_load;
   logic [15:0] cnt_load_val;
   logic        cnt_dec;
   logic [15:0] cnt_digits;
   logic        cnt_zero;

   always_comb begin
      sec_clamped  = clamp_sec(sw);
      min_clamped  = clamp_min(sw, MAX_MIN);
      tick         = (presc_q == TickW'(TICK_DIV - 1));
      last_sec     = (cnt_digits == 16'h0001);
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      case (state_q)
         StSetSec: begin
            cnt_load     = 1'b1;
            cnt_load_val = {8'h00, sec_clamped};
         end
         StSetMin: begin
            cnt_load     = 1'b1;
            cnt_load_val = {min_clamped, preset_sec_q};
         end
         StRun:   cnt_dec = tick && !startStop;  // pause beats a coincident tick
         StAlarm: begin
            if (set || startStop) begin
               cnt_load     = 1'b1;
               cnt_load_val = {preset_min_q, preset_sec_q};
            end
         end
         default: ;
      endcase
   end

   bcd_mmss_down u_counter (
      .clk        (clk),
      .reset      (reset),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .digits_o   (cnt_digits),
      .zero_o     (cnt_zero)
   );

   assign {minTens, minOnes, secTens, secOnes} = cnt_digits;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StSetSec;
         presc_q      <= '0;
         flash_q      <= '0;
         preset_sec_q <= '0;
         preset_min_q <= '0;
         leds         <= '0;
         running      <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StSetSec: begin
               if (set) begin
                  preset_sec_q <= sec_clamped;
                  state_q      <= StSetMin;
               end
            end
            StSetMin: begin
               if (set) begin
                  preset_min_q <= min_clamped;
                  state_q      <= StReady;
               end
            end
            StReady: begin
               if (startStop && !cnt_zero) begin
                  state_q <= StRun;
                  presc_q <= '0;
                  running <= 1'b1;
               end
            end
            StRun: begin
               if (startStop) begin
                  state_q <= StReady;
                  running <= 1'b0;
               end else if (tick) begin
                  presc_q <= '0;
                  if (last_sec) begin
                     state_q <= StAlarm;
                     running <= 1'b0;
                     done    <= 1'b1;
                     leds    <= '1;
                     flash_q <= '0;
                  end
               end else begin
                  presc_q <= presc_q + 1'b1;
               end
            end
            StAlarm: begin
               if (set || startStop) begin
                  state_q <= StReady;
                  leds    <= '0;
               end else if (flash_q == FlashW'(FLASH_DIV - 1)) begin
                  flash_q <= '0;
                  leds    <= ~leds;
               end else begin
                  flash_q <= flash_q + 1'b1;
               end
            end
            default: state_q <= StSetSec;
         endcase
      end
   end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Self-checking bench for egg_timer_ctrl: directed scenarios plus randomized
// stimulus against a seconds-based behavioural model.
module tb_egg_timer_ctrl;

   localparam int unsigned TICK  = 4;
   localparam int unsigned FLASH = 3;
   localparam int unsigned LW    = 4;
   localparam int unsigned MAXM  = 99;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          set = 1'b0;
   logic          startStop = 1'b0;
   logic [7:0]    sw = 8'h00;
   logic [3:0]    minTens, minOnes, secTens, secOnes;
   logic [LW-1:0] leds;
   logic          running, done;
   logic [15:0]   dig;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Model: mode 0 set-sec, 1 set-min, 2 ready, 3 run, 4 alarm; time kept as integers.
   int m_mode = 0, m_min = 0, m_sec = 0, m_pmin = 0, m_psec = 0, m_phase = 0, m_acyc = 0;

   egg_timer_ctrl #(
      .TICK_DIV  (TICK),
      .FLASH_DIV (FLASH),
      .LED_W     (LW),
      .MAX_MIN   (MAXM)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .set       (set),
      .startStop (startStop),
      .sw        (sw),
      .minTens   (minTens),
      .minOnes   (minOnes),
      .secTens   (secTens),
      .secOnes   (secOnes),
      .leds      (leds),
      .running   (running),
      .done      (done)
   );

   assign dig = {minTens, minOnes, secTens, secOnes};

   always #5 clk = ~clk;

   function automatic int lim(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   function automatic logic [15:0] m_digits();
      return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
   endfunction

   function automatic logic [LW-1:0] m_leds();
      return (m_mode == 4 && ((m_acyc / FLASH) % 2) == 0) ? '1 : '0;
   endfunction

   task automatic model_step(input logic r, input logic s, input logic ss, input logic [7:0] v);
      int cs, cm, t;
      cs = lim(int'(v[7:4]), 5) * 10 + lim(int'(v[3:0]), 9);
      cm = lim(lim(int'(v[7:4]), 9) * 10 + lim(int'(v[3:0]), 9), MAXM);
      if (r) begin
         m_mode = 0; m_min = 0; m_sec = 0; m_pmin = 0; m_psec = 0; m_phase = 0; m_acyc = 0;
      end else begin
         case (m_mode)
            0: begin
               m_min = 0; m_sec = cs;
               if (s) begin m_psec = cs; m_mode = 1; end
            end
            1: begin
               m_min = cm; m_sec = m_psec;
               if (s) begin m_pmin = cm; m_mode = 2; end
            end
            2: if (ss && (m_min * 60 + m_sec) != 0) begin m_mode = 3; m_phase = 0; end
            3: begin
               if (ss) m_mode = 2;
               else begin
                  m_phase++;
                  if (m_phase == TICK) begin
                     m_phase = 0;
                     t = m_min * 60 + m_sec - 1;
                     m_min = t / 60; m_sec = t % 60;
                     if (t == 0) begin m_mode = 4; m_acyc = 0; end
                  end
               end
            end
            default: begin
               if (s || ss) begin m_mode = 2; m_min = m_pmin; m_sec = m_psec; end
               else m_acyc++;
            end
         endcase
      end
   endtask

   task automatic cyc(input logic r, input logic s, input logic ss, input logic [7:0] v);
      reset = r; set = s; startStop = ss; sw = v;
      @(posedge clk);
      model_step(r, s, ss, v);
      #1;
      reset = 1'b0; set = 1'b0; startStop = 1'b0;
   endtask

   task automatic program_time(input logic [7:0] s, input logic [7:0] m);
      cyc(1'b0, 1'b0, 1'b0, s);
      cyc(1'b0, 1'b1, 1'b0, s);
      cyc(1'b0, 1'b0, 1'b0, m);
      cyc(1'b0, 1'b1, 1'b0, m);
   endtask

   task automatic test_reset();
      cyc(1'b1, 1'b0, 1'b0, 8'h7C);
      vec_cnt++;
      if (dig !== 16'h0000) begin err_cnt++; $display("FAIL reset_digits: got %h want 0000", dig); end
      vec_cnt++;
      if (leds !== 4'h0) begin err_cnt++; $display("FAIL reset_leds: got %h want 0", leds); end
      vec_cnt++;
      if (running !== 1'b0 || done !== 1'b0) begin
         err_cnt++; $display("FAIL reset_flags: got run=%b done=%b want 0 0", running, done);
      end
   endtask

   task automatic test_clamp();
      cyc(1'b0, 1'b0, 1'b0, 8'h7C);
      vec_cnt++;
      if (dig !== 16'h0059) begin err_cnt++; $display("FAIL clamp_sec: got %h want 0059", dig); end
      cyc(1'b0, 1'b1, 1'b0, 8'h7C);
      cyc(1'b0, 1'b0, 1'b0, 8'h3A);
      vec_cnt++;
      if (dig !== 16'h3959) begin err_cnt++; $display("FAIL set_min_follow: got %h want 3959", dig); end
      cyc(1'b0, 1'b0, 1'b0, 8'hFF);
      vec_cnt++;
      if (dig !== 16'h9959) begin err_cnt++; $display("FAIL clamp_min: got %h want 9959", dig); end
      cyc(1'b0, 1'b1, 1'b0, 8'h12);
      cyc(1'b0, 1'b0, 1'b0, 8'h45);
      vec_cnt++;
      if (dig !== 16'h1259) begin err_cnt++; $display("FAIL ready_hold: got %h want 1259", dig); end
   endtask

   task automatic test_countdown();
      logic [3:0] flash_exp [7];
      flash_exp = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF};
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      program_time(8'h05, 8'h01);
      vec_cnt++;
      if (dig !== 16'h0105) begin err_cnt++; $display("FAIL preset_0105: got %h want 0105", dig); end
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      vec_cnt++;
      if (running !== 1'b1) begin err_cnt++; $display("FAIL run_start: got %b want 1", running); end
      for (int k = 1; k <= 266; k++) begin
         cyc(1'b0, 1'b0, 1'b0, 8'h00);
         if (k == 3 || k == 4 || k == 20 || k == 24 || k == 259 || k == 260) begin
            logic [15:0] want;
            case (k)
               3:       want = 16'h0105;
               4:       want = 16'h0104;
               20:      want = 16'h0100;
               24:      want = 16'h0059;
               259:     want = 16'h0001;
               default: want = 16'h0000;
            endcase
            vec_cnt++;
            if (dig !== want) begin
               err_cnt++; $display("FAIL countdown_k%0d: got %h want %h", k, dig, want);
            end
         end
         if (k == 259 || k == 260 || k == 261) begin
            vec_cnt++;
            if (done !== (k == 260) || running !== (k < 260)) begin
               err_cnt++;
               $display("FAIL done_pulse_k%0d: got done=%b run=%b want %b %b", k, done, running,
                        k == 260, k < 260);
            end
         end
         if (k >= 260) begin
            vec_cnt++;
            if (leds !== flash_exp[k-260]) begin
               err_cnt++; $display("FAIL flash_k%0d: got %h want %h", k, leds, flash_exp[k-260]);
            end
         end
      end
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      vec_cnt++;
      if (dig !== 16'h0105 || leds !== 4'h0 || running !== 1'b0) begin
         err_cnt++; $display("FAIL alarm_reload: got %h leds %h run %b want 0105 0 0", dig, leds, running);
      end
   endtask

   task automatic test_pause_tick();
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      program_time(8'h05, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      for (int k = 1; k <= 11; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      vec_cnt++;
      if (dig !== 16'h0003) begin err_cnt++; $display("FAIL pre_pause: got %h want 0003", dig); end
      cyc(1'b0, 1'b0, 1'b1, 8'h00);  // coincides with the third tick
      vec_cnt++;
      if (dig !== 16'h0003 || running !== 1'b0) begin
         err_cnt++; $display("FAIL pause_vs_tick: got %h run %b want 0003 0", dig, running);
      end
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      vec_cnt++;
      if (dig !== 16'h0003) begin err_cnt++; $display("FAIL paused_hold: got %h want 0003", dig); end
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b0, 1'b0, 1'b0, 8'h00);
         if (k >= 3) begin
            vec_cnt++;
            if (dig !== ((k == 4) ? 16'h0002 : 16'h0003) || running !== 1'b1) begin
               err_cnt++; $display("FAIL resume_k%0d: got %h run %b", k, dig, running);
            end
         end
      end
   endtask

   task automatic test_zero_preset();
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      program_time(8'h00, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      for (int k = 0; k < 8; k++) begin
         vec_cnt++;
         if (running !== 1'b0 || done !== 1'b0 || dig !== 16'h0000) begin
            err_cnt++; $display("FAIL zero_start_%0d: got run=%b done=%b %h", k, running, done, dig);
         end
         cyc(1'b0, 1'b0, 1'b0, 8'h00);
      end
   endtask

   task automatic test_reset_mid();
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      program_time(8'h45, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      vec_cnt++;
      if (dig !== 16'h0040) begin err_cnt++; $display("FAIL run_to_40: got %h want 0040", dig); end
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      vec_cnt++;
      if (dig !== 16'h0000 || leds !== 4'h0 || running !== 1'b0) begin
         err_cnt++; $display("FAIL reset_in_run: got %h leds %h run %b", dig, leds, running);
      end
      program_time(8'h01, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      vec_cnt++;
      if (done !== 1'b1 || leds !== 4'hF) begin
         err_cnt++; $display("FAIL short_alarm: got done=%b leds=%h want 1 F", done, leds);
      end
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      vec_cnt++;
      if (dig !== 16'h0000 || leds !== 4'h0 || done !== 1'b0) begin
         err_cnt++; $display("FAIL reset_in_alarm: got %h leds %h done %b", dig, leds, done);
      end
   endtask

   task automatic test_random();
      logic       r, s, ss;
      logic [7:0] v;
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 4000; k++) begin
         r  = ($urandom_range(0, 299) == 0);
         s  = ($urandom_range(0, 19) == 0);
         ss = ($urandom_range(0, 29) == 0);
         v  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
         cyc(r, s, ss, v);
         vec_cnt++;
         if (dig !== m_digits() || leds !== m_leds() || running !== (m_mode == 3) ||
             done !== (m_mode == 4 && m_acyc == 0)) begin
            err_cnt++;
            $display("FAIL random_%0d: got %h/%h/%b/%b want %h/%h/%b/%b", k, dig, leds, running,
                     done, m_digits(), m_leds(), m_mode == 3, m_mode == 4 && m_acyc == 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clamp();
      test_countdown();
      test_pause_tick();
      test_zero_preset();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
